// File: rtl/acc_16bit_s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Brief    : Shared opcodes, FSM states and command-entry layout for the
//            acc_16bit_s accumulator stage.
// Revision : 1.0 - initial release
// ============================================================================
package acc_pkg;

  // Command opcodes carried in the upper two bits of each FIFO entry
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam int DATA_W  = 16;
  localparam int ENTRY_W = 2 + DATA_W;

  // Status-only state machine encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One buffered command: opcode in the MSBs, operand below
  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // ADD and SUB are the only opcodes that route the adder result and flags
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_16bit_s_adder.sv
`default_nettype none
// ============================================================================
// Module   : adder_16bit_s
// Brief    : 16-bit structural ripple-carry add/sub. Add_ctrl=1 computes
//            A + ~B + 1; O flags two's-complement overflow out of bit 15.
// Revision : 1.0 - initial release
// ============================================================================
module adder_16bit_s (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Add_ctrl,
  output logic [15:0] SUM,
  output logic        C_out,
  output logic        O
);

  logic [16:0] w_carry;
  logic [15:0] w_b;

  // Subtraction inverts B and injects the +1 through the carry-in
  assign w_b        = B ^ {16{Add_ctrl}};
  assign w_carry[0] = Add_ctrl;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign SUM[i]       = A[i] ^ w_b[i] ^ w_carry[i];
    assign w_carry[i+1] = (A[i] & w_b[i]) | (w_carry[i] & (A[i] ^ w_b[i]));
  end

  // Overflow when the carry into the sign bit differs from the carry out
  assign C_out = w_carry[16];
  assign O     = w_carry[16] ^ w_carry[15];

endmodule
`default_nettype wire

// File: rtl/acc_16bit_s.sv
`default_nettype none
// ============================================================================
// Module   : acc_16bit_s
// Brief    : Accumulator stage around adder_16bit_s. Commands arrive over a
//            valid/ready port into a small FIFO, execute one per cycle and
//            produce a registered result with its own valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module acc_16bit_s
  import acc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic                         res_c,
  output logic                         res_o,
  output logic [WIDTH-1:0]             acc,
  output logic                         ovf_sticky,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_c;
  logic             r_res_o;
  logic             r_res_valid;
  logic             r_ovf;

  state_t           r_state;
  state_t           w_state_nxt;

  cmd_t             w_head;
  logic             w_push;
  logic             w_exec;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Handshake qualifiers; a pop happens exactly when a command executes
  assign in_ready = (r_count != C_FULL);
  assign w_push   = in_valid && in_ready;
  assign w_exec   = (r_count != '0) && (!r_res_valid || res_ready);
  assign w_head   = r_mem[r_rd_ptr];

  adder_16bit_s u_adder (
    .A        (r_acc),
    .B        (w_head.data),
    .Add_ctrl (w_head.op == OP_SUB),
    .SUM      (w_sum),
    .C_out    (w_cout),
    .O        (w_ovf)
  );

  // Entry storage needs no reset: pointers and count decide what is live
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{op: in_op, data: in_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_exec) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_exec})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Execute the head command and hold the result until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_res_data  <= '0;
      r_res_c     <= 1'b0;
      r_res_o     <= 1'b0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_exec) begin
      r_res_valid <= 1'b1;
      case (w_head.op)
        OP_LOAD: begin
          r_acc      <= w_head.data;
          r_res_data <= w_head.data;
          r_res_c    <= 1'b0;
          r_res_o    <= 1'b0;
        end
        OP_CLR: begin
          r_acc      <= '0;
          r_res_data <= '0;
          r_res_c    <= 1'b0;
          r_res_o    <= 1'b0;
          r_ovf      <= 1'b0;
        end
        default: begin
          r_acc      <= w_sum;
          r_res_data <= w_sum;
          r_res_c    <= is_arith(w_head.op) & w_cout;
          r_res_o    <= is_arith(w_head.op) & w_ovf;
          r_ovf      <= r_ovf | w_ovf;
        end
      endcase
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Status state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Classify the current cycle; DRAIN only leaves once the result is taken
  always_comb begin
    w_state_nxt = IDLE;
    if (w_exec) begin
      w_state_nxt = RUN;
    end else if (r_res_valid && !res_ready && (r_count != '0)) begin
      w_state_nxt = STALL;
    end else if (r_res_valid && (r_count == '0)) begin
      w_state_nxt = ((r_state == DRAIN) && res_ready) ? IDLE : DRAIN;
    end
  end

  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_c      = r_res_c;
  assign res_o      = r_res_o;
  assign acc        = r_acc;
  assign ovf_sticky = r_ovf;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_acc_16bit_s.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_16bit_s
// Brief    : Scoreboard bench for acc_16bit_s. Stimulus pushes expected
//            results computed by a reference model; a monitor pops and
//            compares on every result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_16bit_s;
  import acc_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        c;
    logic        o;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_c;
  logic        res_o;
  logic [15:0] acc;
  logic        ovf_sticky;
  logic [2:0]  fifo_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        sb[$];
  logic [15:0] m_acc  = '0;
  logic        m_ovf  = 1'b0;

  acc_16bit_s #(.FIFO_DEPTH(4), .WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_c      (res_c),
    .res_o      (res_o),
    .acc        (acc),
    .ovf_sticky (ovf_sticky),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for throughput measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model of the accumulator, independent of the adder structure
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] d);
    exp_t        e;
    logic [16:0] s;
    e = '0;
    case (op)
      OP_LOAD: m_acc = d;
      OP_ADD: begin
        s     = {1'b0, m_acc} + {1'b0, d};
        e.c   = s[16];
        e.o   = (m_acc[15] == d[15]) && (s[15] != m_acc[15]);
        m_acc = s[15:0];
        m_ovf = m_ovf | e.o;
      end
      OP_SUB: begin
        s     = {1'b0, m_acc} + {1'b0, ~d} + 17'd1;
        e.c   = s[16];
        e.o   = (m_acc[15] != d[15]) && (s[15] != m_acc[15]);
        m_acc = s[15:0];
        m_ovf = m_ovf | e.o;
      end
      default: begin
        m_acc = '0;
        m_ovf = 1'b0;
      end
    endcase
    e.data = m_acc;
    e.ovf  = m_ovf;
    return e;
  endfunction

  // Drive one command; the expectation is queued on the accepting edge
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(op, d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_empty", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(res_data), 32'hDEAD_0000);
        end else begin
          e = sb.pop_front();
          chk("res_data",   32'(res_data),   32'(e.data));
          chk("res_c",      32'(res_c),      32'(e.c));
          chk("res_o",      32'(res_o),      32'(e.o));
          chk("ovf_sticky", 32'(ovf_sticky), 32'(e.ovf));
          chk("acc",        32'(acc),        32'(e.data));
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    logic [1:0] op;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_LOAD;
    in_data   = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc",        32'(acc),        32'(0));
    chk("rst_res_valid",  32'(res_valid),  32'(0));
    chk("rst_ovf",        32'(ovf_sticky), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("rst_in_ready",   32'(in_ready),   32'(1));
    @(posedge clk);
    #1;

    // Basic LOAD/ADD with one-cycle latency after accept
    res_ready = 1'b1;
    send(OP_LOAD, 16'h1234);
    chk("lat_load_pre",  32'(res_valid),  32'(0));
    chk("lat_load_cnt",  32'(fifo_count), 32'(1));
    @(posedge clk);
    #1;
    chk("lat_load_post", 32'(res_valid),  32'(1));
    send(OP_ADD, 16'h0001);
    chk("lat_add_pre",   32'(res_valid),  32'(0));
    @(posedge clk);
    #1;
    chk("lat_add_post",  32'(res_valid),  32'(1));
    drain();

    // Signed overflow and sticky clear
    send(OP_LOAD, 16'h7FFF);
    send(OP_ADD,  16'h0001);
    send(OP_CLR,  16'hABCD);
    drain();
    chk("clr_ovf", 32'(ovf_sticky), 32'(0));
    chk("clr_acc", 32'(acc),        32'(0));

    // Subtraction borrow and overflow
    send(OP_LOAD, 16'h0000);
    send(OP_SUB,  16'h0001);
    send(OP_LOAD, 16'h8000);
    send(OP_SUB,  16'h0001);
    drain();

    // Backpressure: fill the FIFO behind a held result
    res_ready = 1'b0;
    send(OP_LOAD, 16'h0000);
    for (int i = 0; i < 4; i++) send(OP_ADD, 16'h0001);
    chk("bp_count_full", 32'(fifo_count), 32'(4));
    chk("bp_in_ready",   32'(in_ready),   32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(res_valid), 32'(1));
      chk("bp_hold_data",  32'(res_data),  32'(sb[0].data));
      chk("bp_hold_c",     32'(res_c),     32'(sb[0].c));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_data  = 16'h0100;
    $display("protocol error: bench drove in_valid while in_ready=0 (push must be ignored)");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_full_push_ignored", 32'(fifo_count), 32'(4));
    fork
      send(OP_ADD, 16'h0001);
    join_none
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_back_to_back", 32'(res_valid), 32'(1));
    end
    drain();

    // Streaming: one command per cycle with consumer always ready
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_SUB;
      send(op, 16'($urandom));
    end
    drain();
    chk("stream_throughput", 32'((cyc - start) <= 106), 32'(1));

    // Asynchronous reset with work in flight
    res_ready = 1'b0;
    send(OP_LOAD, 16'h0005);
    for (int i = 0; i < 3; i++) send(OP_ADD, 16'h0001);
    chk("mid_count",  32'(fifo_count), 32'(3));
    chk("mid_valid",  32'(res_valid),  32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    chk("arst_acc",   32'(acc),        32'(0));
    chk("arst_data",  32'(res_data),   32'(0));
    chk("arst_valid", 32'(res_valid),  32'(0));
    chk("arst_count", 32'(fifo_count), 32'(0));
    chk("arst_c_o",   32'({res_c, res_o, ovf_sticky}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_result", 32'(res_valid), 32'(0));
    end
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_16bit_s.md
Name: acc_16bit_s

Overview:
- Sequential accumulator stage directly upstream of, and wrapped around, the 16-bit structural add/sub unit adder_16bit_s.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small command FIFO.
- Drives the adder with A = accumulator and B = operand, then registers SUM/C_out/O into the accumulator and a result port with its own valid/ready handshake.
- Keeps a sticky signed-overflow flag.

Parameters:
- FIFO_DEPTH, 4, number of command FIFO entries; power of two, minimum 2.
- WIDTH, 16, datapath width; fixed at 16 to match adder_16bit_s.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command; equals !full.
- in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- in_data  input  16  operand B (ignored for CLR).
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  16  accumulator value after the command.
- res_c  output  1  adder C_out for ADD/SUB; 0 for LOAD/CLR.
- res_o  output  1  adder O (signed overflow) for ADD/SUB; 0 for LOAD/CLR.
- acc  output  16  live accumulator register.
- ovf_sticky  output  1  OR of res_o since the last CLR or reset.
- fifo_count  output  3  entries currently in the FIFO, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc, res_data, res_c, res_o, res_valid, ovf_sticky all 0.
  - FIFO pointers and count 0; FSM goes to IDLE.
  - A command or result in flight is discarded.
  - in_ready is 1 from the first edge after reset release.
- Push: on in_valid && in_ready at edge N, the entry is written to the tail.
  - No bypass: an empty FIFO with a simultaneous push still executes the command at N+1 at the earliest.
- Execute enable: exec = (count != 0) && (!res_valid || res_ready).
- On exec at edge N+1:
  - The head is popped.
  - acc and res_data are updated.
  - res_valid is set to 1.
  - Minimum latency from command accept to res_valid high is 1 cycle.
- Adder drive (combinational): A = acc, B = head operand, Add_ctrl = 1 for SUB, 0 otherwise.
  - SUB computes acc + ~B + 1, so res_c = 1 means no borrow.
  - O is two's-complement overflow of bit 15.
- Per-opcode update:
  - LOAD: acc <= B; res_c = 0; res_o = 0.
  - ADD / SUB: acc <= SUM; res_c = C_out; res_o = O; ovf_sticky <= ovf_sticky | O.
  - CLR: acc <= 0; ovf_sticky <= 0; res_c = 0; res_o = 0.
- Wrap-around: 16-bit modulo arithmetic; no saturation.
- Result handshake:
  - res_valid && res_ready with no exec clears res_valid.
  - Accept and exec in the same cycle keeps res_valid at 1 and loads the new result, giving full throughput of 1 result/cycle.
  - res_data/res_c/res_o stay stable while res_valid && !res_ready.
- FIFO boundaries:
  - Full: in_ready = 0.
  - A push and a pop in the same cycle leave count unchanged.
  - A push while full is ignored; the bench must flag it as a protocol error.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM (status only; it does not gate the datapath beyond exec):
  - IDLE: count == 0 and !res_valid.
  - RUN: exec this cycle.
  - STALL: res_valid && !res_ready && count != 0.
  - Transitions are re-evaluated every cycle from count, res_valid and res_ready.
  - DRAIN: count == 0 && res_valid; goes to IDLE on res_ready.
- Reset mid-operation: an asynchronous assert clears everything immediately. Commands not yet executed are lost, and no result is emitted for them.

Decomposition:
- Shared package acc_pkg:
  - op localparams OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11.
  - FSM state encodings IDLE, RUN, STALL, DRAIN.
  - FIFO entry width 18 (op + data).
- One sub-module is natural: the existing adder_16bit_s, instantiated once. The FIFO stays inline.

Test Plan:
- Reset, then LOAD 0x1234, ADD 0x0001 with res_ready = 1 -> results 0x1234 (c = 0, o = 0) then 0x1235; res_valid is high 1 cycle after each accept.
- LOAD 0x7FFF, ADD 0x0001 -> res_data 0x8000, res_o = 1, res_c = 0, ovf_sticky = 1; a following CLR -> 0x0000 and ovf_sticky = 0.
- LOAD 0x0000, SUB 0x0001 -> res_data 0xFFFF, res_c = 0 (borrow), res_o = 0; LOAD 0x8000, SUB 0x0001 -> 0x7FFF with res_o = 1, res_c = 1.
- Backpressure: hold res_ready = 0 and push 5 ADD 0x0001 after LOAD 0:
  - First result is held stable.
  - in_ready drops after 4 queued entries (fifo_count = 4).
  - Releasing res_ready gives 0x0001..0x0005 on consecutive cycles.
- Streaming: in_valid and res_ready held high for 100 random ADD/SUB commands -> one result per cycle, matching a bench model of acc, C_out and O.
- Assert rst_n low while 3 commands are queued and res_valid = 1 -> all outputs 0 and fifo_count = 0 immediately; after release, no stale result appears.
